// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared state enum and constants for the fetch sequencer
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [31:0] PC_STEP              = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

endpackage

// File: rtl/pc_next_mux.sv
// rtl/pc_next_mux.sv - jump/branch/+4 priority select with redirect alignment handling
// Optional feature: PC_SEQ_ALIGN_CHECK_EN traps misaligned redirect targets.
module pc_next_mux
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] TRAP_VECTOR = DEFAULT_TRAP_VECTOR
) (
    input  logic [31:0] i_pc,
    input  logic        i_jump,
    input  logic [31:0] i_jump_target,
    input  logic        i_br_taken,
    input  logic [31:0] i_br_target,
    output logic [31:0] o_pc_next,
    output logic        o_misaligned
);

    logic        w_redirect;
    logic [31:0] w_target;
`ifdef PC_SEQ_ALIGN_CHECK_EN
    logic        w_bad;
`endif

    always_comb begin
        w_redirect = i_jump | i_br_taken;
        w_target   = i_jump ? i_jump_target : i_br_target;
`ifdef PC_SEQ_ALIGN_CHECK_EN
        w_bad        = w_redirect && (w_target[1:0] != 2'b00);
        o_misaligned = w_bad;
        if (!w_redirect)
            o_pc_next = i_pc + PC_STEP;
        else if (w_bad)
            o_pc_next = TRAP_VECTOR;
        else
            o_pc_next = w_target;
`else
        // Without the check, misaligned targets are silently word-aligned.
        o_misaligned = 1'b0;
        o_pc_next    = w_redirect ? {w_target[31:2], 2'b00} : i_pc + PC_STEP;
`endif
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC fetch sequencer: imem handshake, stall hold, redirects, instret
// Optional feature: PC_SEQ_ALIGN_CHECK_EN (handled in pc_next_mux).
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR,
    parameter int unsigned WAIT_MAX     = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic        stall,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [31:0] PCNext,
    output logic        fetch_valid,
    output logic [31:0] instret,
    output logic        fetch_err,
    output logic        misaligned
);

    // The counter only ever holds 0..WAIT_MAX-1; it clears on the timeout cycle.
    localparam int WAIT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [WAIT_W-1:0]   r_wait;
    logic [WAIT_W-1:0]   w_wait_next;
    logic [31:0]         r_instret;
    logic                w_advance;
    logic [31:0]         w_mux_next;
    logic                w_mux_mis;

    pc_next_mux #(
        .TRAP_VECTOR (TRAP_VECTOR)
    ) u_pc_next_mux (
        .i_pc          (PC),
        .i_jump        (jump),
        .i_jump_target (jump_target),
        .i_br_taken    (br_taken),
        .i_br_target   (br_target),
        .o_pc_next     (w_mux_next),
        .o_misaligned  (w_mux_mis)
    );

    always_comb begin
        w_state_next = r_state;
        w_wait_next  = r_wait;
        imem_req     = 1'b0;
        fetch_valid  = 1'b0;
        fetch_err    = 1'b0;
        PCNext       = PC;
        case (r_state)
            ST_BOOT: begin
                PCNext       = RESET_VECTOR;
                w_state_next = ST_FETCH;
                w_wait_next  = '0;
            end
            ST_FETCH: begin
                imem_req    = 1'b1;
                fetch_valid = imem_ack;
                if (imem_ack) begin
                    w_wait_next = '0;
                    if (stall)
                        w_state_next = ST_HOLD;
                end else if (r_wait == WAIT_LAST) begin
                    fetch_err   = 1'b1;
                    w_wait_next = '0;
                end else begin
                    w_wait_next = r_wait + WAIT_W'(1);
                end
            end
            ST_HOLD: begin
                fetch_valid = 1'b1;
                w_wait_next = '0;
                if (!stall)
                    w_state_next = ST_FETCH;
            end
            default: begin
                w_state_next = ST_BOOT;
                w_wait_next  = '0;
            end
        endcase

        w_advance  = fetch_valid & ~stall;
        misaligned = w_advance & w_mux_mis;
        if (w_advance)
            PCNext = w_mux_next;

        // Reset overrides everything combinationally so the pending request is dropped.
        if (reset) begin
            PCNext      = RESET_VECTOR;
            imem_req    = 1'b0;
            fetch_valid = 1'b0;
            fetch_err   = 1'b0;
            misaligned  = 1'b0;
            w_advance   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_BOOT;
            r_wait    <= '0;
            r_instret <= '0;
        end else begin
            r_state <= w_state_next;
            r_wait  <= w_wait_next;
            if (w_advance)
                r_instret <= r_instret + 32'd1;
        end
    end

    assign instret = r_instret;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed plus randomized checks of pc_sequencer against a behavioural model
module tb_pc_sequencer;

    localparam logic [31:0] RV       = 32'h0000_0000;
    localparam logic [31:0] TV       = 32'h0000_0100;
    localparam int          WAIT_MAX = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PC;
    logic        imem_req;
    logic        imem_ack;
    logic        stall;
    logic        jump;
    logic [31:0] jump_target;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] PCNext;
    logic        fetch_valid;
    logic [31:0] instret;
    logic        fetch_err;
    logic        misaligned;

    pc_sequencer #(
        .RESET_VECTOR (RV),
        .TRAP_VECTOR  (TV),
        .WAIT_MAX     (WAIT_MAX)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .PC          (PC),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .stall       (stall),
        .jump        (jump),
        .jump_target (jump_target),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .PCNext      (PCNext),
        .fetch_valid (fetch_valid),
        .instret     (instret),
        .fetch_err   (fetch_err),
        .misaligned  (misaligned)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: the bench plays Contador_PC and tracks the fetch situation.
    bit          booting   = 1'b1;
    bit          holding   = 1'b0;
    int          misses    = 0;
    logic [31:0] pc_m      = RV;
    logic [31:0] instret_m = 32'd0;
    bit          e_req, e_valid, e_err, e_mis, e_adv;
    logic [31:0] e_next;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit r, input bit a, input bit s,
                         input bit j, input logic [31:0] jt,
                         input bit b, input logic [31:0] bt);
        logic [31:0] tgt;
        reset = r; imem_ack = a; stall = s;
        jump = j; jump_target = jt; br_taken = b; br_target = bt;
        PC = pc_m;
        e_req = 0; e_valid = 0; e_err = 0; e_mis = 0; e_adv = 0;
        e_next = pc_m;
        if (r || booting) begin
            e_next = RV;
        end else if (holding) begin
            e_valid = 1;
            e_adv   = !s;
        end else begin
            e_req   = 1;
            e_valid = a;
            e_adv   = a && !s;
            e_err   = !a && (misses + 1 == WAIT_MAX);
        end
        if (e_adv) begin
            tgt = j ? jt : bt;
            if (!(j || b))
                e_next = pc_m + 32'd4;
            else if (tgt[1:0] != 2'b00) begin
`ifdef PC_SEQ_ALIGN_CHECK_EN
                e_next = TV;
                e_mis  = 1;
`else
                e_next = {tgt[31:2], 2'b00};
`endif
            end else
                e_next = tgt;
        end
        #4;
        check1 ("imem_req",    imem_req,    e_req);
        check1 ("fetch_valid", fetch_valid, e_valid);
        check1 ("fetch_err",   fetch_err,   e_err);
        check1 ("misaligned",  misaligned,  e_mis);
        check32("PCNext",      PCNext,      e_next);
        check32("instret",     instret,     instret_m);
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            booting = 1; holding = 0; misses = 0; instret_m = 0;
        end else begin
            if (booting)
                booting = 0;
            else if (holding) begin
                if (e_adv) holding = 0;
            end else if (imem_ack) begin
                misses = 0;
                if (stall) holding = 1;
            end else
                misses = e_err ? 0 : misses + 1;
            if (e_adv) instret_m = instret_m + 32'd1;
        end
        pc_m = e_next;
        #1;
    endtask

    task automatic step(input bit r, input bit a, input bit s,
                        input bit j, input logic [31:0] jt,
                        input bit b, input logic [31:0] bt);
        drive(r, a, s, j, jt, b, bt);
        tick();
    endtask

    initial begin
        int          errs;
        logic [31:0] jt_r, bt_r;

        // Reset, then ack tied high
        step(1, 1, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0);
        check32("reset_instret", instret, 32'd0);
        tick();
        drive(0, 1, 0, 0, 0, 0, 0);
        check32("boot_pcnext", PCNext, 32'h0);
        check1 ("boot_req", imem_req, 1'b0);
        tick();
        step(0, 1, 0, 0, 0, 0, 0);       // PC 0 -> 4
        step(0, 1, 0, 0, 0, 0, 0);       // PC 4 -> 8
        check32("instret_two", instret, 32'd2);

        // Ack delayed 3 cycles at PC=8
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            check32("delay_hold_pc", PCNext, 32'h8);
            tick();
        end
        drive(0, 1, 0, 0, 0, 0, 0);
        check32("delay_ack_pc", PCNext, 32'hC);
        check1 ("delay_ack_valid", fetch_valid, 1'b1);
        tick();
        step(0, 1, 0, 0, 0, 0, 0);       // PC 12 -> 16

        // Stall for 2 cycles during ack at PC=16
        drive(0, 1, 1, 1, 32'h200, 0, 0);
        check32("stall_ack_pc", PCNext, 32'h10);
        tick();
        drive(0, 0, 1, 0, 0, 0, 0);
        check32("hold_pc", PCNext, 32'h10);
        check32("hold_instret", instret, 32'd4);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        check32("hold_release_pc", PCNext, 32'h14);
        tick();

        // Jump beats branch on an advance; redirect ignored when not advancing
        drive(0, 1, 0, 1, 32'h40, 1, 32'h80);
        check32("jump_prio", PCNext, 32'h40);
        tick();
        drive(0, 0, 0, 1, 32'h300, 1, 32'h380);
        check32("redirect_ignored", PCNext, 32'h40);
        tick();
        step(0, 1, 0, 0, 0, 0, 0);       // PC 0x40 -> 0x44

        // Fetch timeout: exactly one fetch_err pulse over WAIT_MAX ack-free cycles
        errs = 0;
        for (int i = 0; i < WAIT_MAX; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            if (fetch_err) errs++;
            check1("timeout_req", imem_req, 1'b1);
            tick();
        end
        check32("timeout_pulses", errs, 32'd1);

        // Misaligned branch target
        drive(0, 1, 0, 0, 0, 1, 32'h42);
`ifdef PC_SEQ_ALIGN_CHECK_EN
        check32("mis_pcnext", PCNext, 32'h100);
        check1 ("mis_flag", misaligned, 1'b1);
`else
        check32("mis_pcnext", PCNext, 32'h40);
        check1 ("mis_flag", misaligned, 1'b0);
`endif
        tick();

        // Reset while in HOLD at 0x24
        step(0, 1, 0, 1, 32'h24, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0);
        drive(1, 0, 1, 0, 0, 0, 0);
        check1("rst_hold_valid", fetch_valid, 1'b0);
        tick();
        drive(0, 1, 0, 0, 0, 0, 0);
        check32("rst_hold_instret", instret, 32'd0);
        check32("rst_hold_boot_pc", PCNext, RV);
        tick();
        drive(0, 1, 0, 0, 0, 0, 0);
        check1("rst_refetch_req", imem_req, 1'b1);
        tick();

        // PC wrap at the top of the address space
        step(0, 1, 0, 1, 32'hFFFF_FFFC, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        check32("pc_wrap", PCNext, 32'h0);
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            jt_r = $urandom();
            bt_r = $urandom();
            if ($urandom_range(3) != 0) jt_r[1:0] = 2'b00;
            if ($urandom_range(3) != 0) bt_r[1:0] = 2'b00;
            if ($urandom_range(15) == 0) jt_r = 32'hFFFF_FFFC;
            step($urandom_range(59) == 0,
                 $urandom_range(9) < 6,
                 $urandom_range(3) == 0,
                 $urandom_range(9) == 0, jt_r,
                 $urandom_range(6) == 0, bt_r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
